// File: rtl/postfix_pkg.sv
// Shared types and token field encodings for the postfix (RPN) evaluator.
package postfix_pkg;

    localparam logic [1:0] TOK_POS = 2'b00;
    localparam logic [1:0] TOK_NEG = 2'b01;
    localparam logic [1:0] TOK_OP  = 2'b10;
    localparam logic [1:0] TOK_END = 2'b11;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_ILL = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        WRITE,
        DONE
    } state_e;

endpackage

// File: rtl/sm_alu.sv
// Combinational sign-magnitude add/sub/mul with magnitude saturation and -0 folding.
module sm_alu
    import postfix_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  op_e               op,
    output logic [DATA_W-1:0] result,
    output logic              ovf
);

    localparam int M = DATA_W - 1;
    localparam logic [M-1:0] MAX_MAG = '1;

    logic           sa, sb, sign;
    logic [M-1:0]   ma, mb, mag;
    logic [M:0]     sum;
    logic [2*M-1:0] prod;

    assign sa = a[M];
    assign ma = a[M-1:0];
    assign mb = b[M-1:0];

    always_comb begin
        sb   = b[M] ^ (op == OP_SUB);
        sum  = '0;
        prod = '0;
        sign = 1'b0;
        mag  = '0;
        ovf  = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                if (sa == sb) begin
                    sum  = {1'b0, ma} + {1'b0, mb};
                    sign = sa;
                    if (sum[M]) begin
                        mag = MAX_MAG;
                        ovf = 1'b1;
                    end else begin
                        mag = sum[M-1:0];
                    end
                end else if (ma >= mb) begin
                    mag  = ma - mb;
                    sign = sa;
                end else begin
                    mag  = mb - ma;
                    sign = sb;
                end
            end
            OP_MUL: begin
                prod = (2*M)'(ma) * (2*M)'(mb);
                sign = sa ^ b[M];
                if (prod > {{M{1'b0}}, MAX_MAG}) begin
                    mag = MAX_MAG;
                    ovf = 1'b1;
                end else begin
                    mag = prod[M-1:0];
                end
            end
            default: ;
        endcase
        if (mag == '0) sign = 1'b0;
        result = {sign, mag};
    end

endmodule

// File: rtl/postfix_eval_sm.sv
// Postfix expression evaluator: fetches byte tokens from memory, evaluates on a
// register stack and writes the result big-endian at RESULT_ADDR.
module postfix_eval_sm
    import postfix_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 10,
    parameter int STACK_DEPTH = 16,
    parameter int RESULT_ADDR = 1000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    output logic [ADDR_W-1:0] ADRS,
    output logic              R_WB,
    inout  logic [7:0]        DATA,
    output logic              FINISH,
    output logic              BUSY,
    output logic              ERR,
    output logic              OVF
);

    localparam int NB     = DATA_W / 8;
    localparam int IDX_W  = $clog2(STACK_DEPTH);
    localparam int PTR_W  = $clog2(STACK_DEPTH + 1);
    localparam int WIDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [ADDR_W-1:0] RES_A  = ADDR_W'(RESULT_ADDR);
    localparam logic [PTR_W-1:0]  FULL   = PTR_W'(STACK_DEPTH);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   adrs_q, adrs_d;
    logic                rwb_q, rwb_d;
    logic [7:0]          dout_q, dout_d;
    logic                finish_q, finish_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;
    logic                ovf_q, ovf_d;
    logic [PTR_W-1:0]    sp_q, sp_d;
    logic [DATA_W-1:0]   stack_q [STACK_DEPTH];
    logic [DATA_W-1:0]   stack_d [STACK_DEPTH];
    op_e                 op_q, op_d;
    logic [WIDX_W-1:0]   widx_q, widx_d;
    logic [DATA_W-1:0]   res_q, res_d;

    logic [IDX_W-1:0]    push_idx, b_idx, a_idx;
    logic [DATA_W-1:0]   opa, opb, alu_res;
    logic                alu_ovf;
    logic [7:0]          tok;

    assign push_idx = IDX_W'(sp_q);
    assign b_idx    = IDX_W'(sp_q - PTR_W'(1));
    assign a_idx    = IDX_W'(sp_q - PTR_W'(2));
    assign opb      = stack_q[b_idx];
    assign opa      = stack_q[a_idx];
    assign tok      = DATA;

    sm_alu #(.DATA_W(DATA_W)) u_alu (
        .a      (opa),
        .b      (opb),
        .op     (op_q),
        .result (alu_res),
        .ovf    (alu_ovf)
    );

    always_comb begin
        state_d  = state_q;
        adrs_d   = adrs_q;
        rwb_d    = rwb_q;
        dout_d   = dout_q;
        finish_d = 1'b0;
        busy_d   = busy_q;
        err_d    = err_q;
        ovf_d    = ovf_q;
        sp_d     = sp_q;
        stack_d  = stack_q;
        op_d     = op_q;
        widx_d   = widx_q;
        res_d    = res_q;
        case (state_q)
            IDLE: begin
                if (START) begin
                    state_d = FETCH;
                    adrs_d  = '0;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    ovf_d   = 1'b0;
                    sp_d    = '0;
                end
            end
            FETCH: begin
                if (adrs_q >= RES_A) begin
                    state_d  = DONE;
                    err_d    = 1'b1;
                    finish_d = 1'b1;
                end else begin
                    state_d = DECODE;
                end
            end
            DECODE: begin
                case (tok[7:6])
                    TOK_POS, TOK_NEG: begin
                        if (sp_q == FULL) begin
                            state_d  = DONE;
                            err_d    = 1'b1;
                            finish_d = 1'b1;
                        end else begin
                            stack_d[push_idx] = {tok[6], {(DATA_W-7){1'b0}}, tok[5:0]};
                            sp_d    = sp_q + PTR_W'(1);
                            adrs_d  = adrs_q + ADDR_W'(1);
                            state_d = FETCH;
                        end
                    end
                    TOK_OP: begin
                        if (op_e'(tok[1:0]) == OP_ILL || sp_q < PTR_W'(2)) begin
                            state_d  = DONE;
                            err_d    = 1'b1;
                            finish_d = 1'b1;
                        end else begin
                            op_d    = op_e'(tok[1:0]);
                            adrs_d  = adrs_q + ADDR_W'(1);
                            state_d = EXEC;
                        end
                    end
                    default: begin
                        if (sp_q != PTR_W'(1)) begin
                            state_d  = DONE;
                            err_d    = 1'b1;
                            finish_d = 1'b1;
                        end else begin
                            // res_q holds the bytes still to be written, MS byte first
                            dout_d  = stack_q[0][DATA_W-1 -: 8];
                            res_d   = stack_q[0] << 8;
                            adrs_d  = RES_A;
                            rwb_d   = 1'b0;
                            widx_d  = '0;
                            state_d = WRITE;
                        end
                    end
                endcase
            end
            EXEC: begin
                stack_d[a_idx] = alu_res;
                sp_d    = sp_q - PTR_W'(1);
                ovf_d   = ovf_q | alu_ovf;
                state_d = FETCH;
            end
            WRITE: begin
                if (widx_q == WIDX_W'(NB - 1)) begin
                    rwb_d    = 1'b1;
                    finish_d = 1'b1;
                    state_d  = DONE;
                end else begin
                    widx_d = widx_q + WIDX_W'(1);
                    adrs_d = adrs_q + ADDR_W'(1);
                    dout_d = res_q[DATA_W-1 -: 8];
                    res_d  = res_q << 8;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        stack_q <= stack_d;
        if (RST) begin
            state_q  <= IDLE;
            adrs_q   <= '0;
            rwb_q    <= 1'b1;
            dout_q   <= '0;
            finish_q <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
            sp_q     <= '0;
            op_q     <= OP_ADD;
            widx_q   <= '0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            adrs_q   <= adrs_d;
            rwb_q    <= rwb_d;
            dout_q   <= dout_d;
            finish_q <= finish_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            ovf_q    <= ovf_d;
            sp_q     <= sp_d;
            op_q     <= op_d;
            widx_q   <= widx_d;
            res_q    <= res_d;
        end
    end

    // Bus is released as soon as RST is seen, not one cycle later.
    assign DATA   = (!rwb_q && !RST) ? dout_q : 'z;
    assign ADRS   = adrs_q;
    assign R_WB   = rwb_q;
    assign FINISH = finish_q;
    assign BUSY   = busy_q;
    assign ERR    = err_q;
    assign OVF    = ovf_q;

endmodule

// File: tb/tb_postfix_eval_sm.sv
// Scoreboard bench for postfix_eval_sm: directed token programs with hand-computed results.
module tb_postfix_eval_sm;

    typedef struct {
        string      name;
        logic       err;
        logic       ovf;
        logic [7:0] b0;
        logic [7:0] b1;
        int         adrs;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [9:0] adrs;
    logic       r_wb, finish, busy, err, ovf;
    wire  [7:0] data;

    logic [7:0] mem [1024];
    logic [7:0] rd_q;
    logic [7:0] prog [$];

    exp_t sb [$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) rd_q <= mem[adrs];
    assign data = r_wb ? rd_q : 8'hzz;

    postfix_eval_sm #(
        .DATA_W      (16),
        .ADDR_W      (10),
        .STACK_DEPTH (16),
        .RESULT_ADDR (1000)
    ) dut (
        .CLK    (clk),
        .RST    (rst),
        .START  (start),
        .ADRS   (adrs),
        .R_WB   (r_wb),
        .DATA   (data),
        .FINISH (finish),
        .BUSY   (busy),
        .ERR    (err),
        .OVF    (ovf)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: logs write cycles and BUSY length, checks against scoreboard at FINISH.
    int         wr_n = 0;
    int         busy_cyc = 0;
    logic [9:0] wr_a [2];
    logic [7:0] wr_d [2];

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            wr_n     = 0;
            busy_cyc = 0;
        end else begin
            if (busy) busy_cyc++;
            if (!r_wb) begin
                if (wr_n < 2) begin
                    wr_a[wr_n] = adrs;
                    wr_d[wr_n] = data;
                end
                wr_n++;
            end
            if (finish) begin
                if (sb.size() == 0) begin
                    chk("unexpected_finish", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_err"}, 32'(err), 32'(e.err));
                    chk({e.name, "_ovf"}, 32'(ovf), 32'(e.ovf));
                    chk({e.name, "_busy_at_finish"}, 32'(busy), 32'd1);
                    chk({e.name, "_adrs_at_finish"}, 32'(adrs), 32'(e.adrs));
                    chk({e.name, "_busy_cycles"}, 32'(busy_cyc), 32'(e.cyc));
                    if (e.err) begin
                        chk({e.name, "_write_count"}, 32'(wr_n), 32'd0);
                    end else begin
                        chk({e.name, "_write_count"}, 32'(wr_n), 32'd2);
                        chk({e.name, "_wr0_addr"}, 32'(wr_a[0]), 32'd1000);
                        chk({e.name, "_wr0_data"}, 32'(wr_d[0]), 32'(e.b0));
                        chk({e.name, "_wr1_addr"}, 32'(wr_a[1]), 32'd1001);
                        chk({e.name, "_wr1_data"}, 32'(wr_d[1]), 32'(e.b1));
                    end
                end
                wr_n     = 0;
                busy_cyc = 0;
            end
        end
    end

    task automatic load();
        for (int i = 0; i < 1024; i++) mem[i] = 8'hC0;
        foreach (prog[i]) mem[i] = prog[i];
    endtask

    task automatic run(input string nm, input logic e_err, input logic e_ovf,
                       input logic [7:0] b0, input logic [7:0] b1,
                       input int e_adrs, input int e_cyc, input bit poke);
        exp_t x;
        bit   seen;
        load();
        x.name = nm; x.err = e_err; x.ovf = e_ovf; x.b0 = b0; x.b1 = b1;
        x.adrs = e_adrs; x.cyc = e_cyc;
        sb.push_back(x);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 4000 && !seen; n++) begin
            @(negedge clk);
            if (finish) seen = 1'b1;
            start = poke && (n == 3);
        end
        start = 1'b0;
        if (!seen) begin
            chk({nm, "_timeout"}, 32'd0, 32'd1);
            sb.delete();
        end
        repeat (3) @(negedge clk);
        chk({nm, "_err_hold"}, 32'(err), 32'(e_err));
        chk({nm, "_idle_busy"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got_write;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_adrs", 32'(adrs), 32'd0);
        chk("rst_r_wb", 32'(r_wb), 32'd1);
        chk("rst_finish", 32'(finish), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        prog = {8'h03, 8'h04, 8'h80, 8'h02, 8'h82, 8'hC0};
        run("t_3_4_add_2_mul", 1'b0, 1'b0, 8'h00, 8'h0E, 1001, 17, 1'b0);
        prog = {8'h05, 8'h47, 8'h80, 8'hC0};
        run("t_5_m7_add", 1'b0, 1'b0, 8'h80, 8'h02, 1001, 12, 1'b1);
        prog = {8'h3F, 8'h3F, 8'h82, 8'h3F, 8'h82, 8'hC0};
        run("t_sat_mul", 1'b0, 1'b1, 8'h7F, 8'hFF, 1001, 17, 1'b0);
        prog = {8'h03, 8'h80, 8'hC0};
        run("t_underflow", 1'b1, 1'b0, 8'h00, 8'h00, 1, 5, 1'b0);
        prog = {8'h43, 8'h44, 8'h82, 8'hC0};
        run("t_m3_m4_mul", 1'b0, 1'b0, 8'h00, 8'h0C, 1001, 12, 1'b0);
        prog = {8'h05, 8'h05, 8'h81, 8'hC0};
        run("t_5_5_sub_zero", 1'b0, 1'b0, 8'h00, 8'h00, 1001, 12, 1'b0);
        prog = {8'h03, 8'h04, 8'hC0};
        run("t_end_depth2", 1'b1, 1'b0, 8'h00, 8'h00, 2, 7, 1'b0);
        prog = {8'h03, 8'h04, 8'h83};
        run("t_illegal_op", 1'b1, 1'b0, 8'h00, 8'h00, 2, 7, 1'b0);

        prog = {};
        for (int i = 0; i < 17; i++) prog.push_back(8'h01);
        prog.push_back(8'hC0);
        run("t_stack_full", 1'b1, 1'b0, 8'h00, 8'h00, 16, 35, 1'b0);

        prog = {};
        prog.push_back(8'h01);
        for (int i = 1; i < 1000; i++) prog.push_back((i % 2 == 1) ? 8'h01 : 8'h80);
        run("t_addr_limit", 1'b1, 1'b0, 8'h00, 8'h00, 1000, 2501, 1'b0);

        // Simultaneous START and RST: reset must win.
        @(posedge clk); #1 begin start = 1'b1; rst = 1'b1; end
        @(posedge clk); #1 begin start = 1'b0; rst = 1'b0; end
        @(negedge clk);
        chk("rst_start_busy", 32'(busy), 32'd0);
        chk("rst_start_err_cleared", 32'(err), 32'd0);
        @(posedge clk); #1;

        // Abort in the middle of the result write.
        prog = {8'h03, 8'h04, 8'h80, 8'h02, 8'h82, 8'hC0};
        load();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        got_write = 1'b0;
        for (int n = 0; n < 100 && !got_write; n++) begin
            @(negedge clk);
            if (!r_wb) got_write = 1'b1;
        end
        chk("abort_reached_write", 32'(got_write), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_r_wb", 32'(r_wb), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_adrs", 32'(adrs), 32'd0);
        chk("abort_finish", 32'(finish), 32'd0);
        rst = 1'b0;
        run("t_rerun_after_abort", 1'b0, 1'b0, 8'h00, 8'h0E, 1001, 17, 1'b0);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
